// File: rtl/ex_issue_pkg.sv
// Shared types for the decode-to-execute issue buffer.
// Optional feature macro: EX_ISSUE_SKID_EN (second skid slot, registered id_ready).
package ex_issue_pkg;

    localparam int ALU_OP_W  = 14;
    localparam int GPR_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        logic [XLEN-1:0]      src1;
        logic [XLEN-1:0]      src2;
        logic [GPR_IDX_W-1:0] rd;
        logic                 rf_we;
        logic [XLEN-1:0]      pc;
    } ex_issue_pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ex_issue_state_e;

endpackage

// File: rtl/ex_issue_slot.sv
// One payload register with a valid bit.
// Reset zeroes payload and valid; clear drops valid only and wins over load.
import ex_issue_pkg::*;

module ex_issue_slot (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_ld,
    input  ex_issue_pkt_t i_d,
    output logic          o_vld,
    output ex_issue_pkt_t o_q
);

    logic          r_vld;
    ex_issue_pkt_t r_q;

    // Valid bit and payload; payload only changes on an effective load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_q   <= '0;
        end else begin
            if (i_clr) begin
                r_vld <= 1'b0;
            end else if (i_ld) begin
                r_vld <= 1'b1;
                r_q   <= i_d;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_q   = r_q;

endmodule

// File: rtl/ex_issue_buf.sv
// Decode-to-execute issue buffer (main slot plus optional skid slot).
// Define EX_ISSUE_SKID_EN for the two-slot build with a registered id_ready.
import ex_issue_pkg::*;

module ex_issue_buf #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 14,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [DATA_W-1:0] id_src1,
    input  logic [DATA_W-1:0] id_src2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_rf_we,
    input  logic [DATA_W-1:0] id_pc,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0] ex_src1,
    output logic [DATA_W-1:0] ex_src2,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_rf_we,
    output logic [DATA_W-1:0] ex_pc
);

    ex_issue_state_e r_state;
    ex_issue_state_e w_state_nxt;

    ex_issue_pkt_t w_in_pkt;
    ex_issue_pkt_t w_main_d;
    ex_issue_pkt_t w_main_q;
    logic          w_main_vld;
    logic          w_main_ld;
    logic          w_main_clr;
    logic          w_accept;
    logic          w_issue;

`ifdef EX_ISSUE_SKID_EN
    ex_issue_pkt_t w_skid_q;
    logic          w_skid_vld;
    logic          w_skid_ld;
    logic          w_skid_clr;
`endif

    assign w_in_pkt.alu_op = id_alu_op;
    assign w_in_pkt.src1   = id_src1;
    assign w_in_pkt.src2   = id_src2;
    assign w_in_pkt.rd     = id_rd;
    assign w_in_pkt.rf_we  = id_rf_we;
    assign w_in_pkt.pc     = id_pc;

`ifdef EX_ISSUE_SKID_EN
    // Only full when both slots hold work, so ready never sees ex_ready.
    assign id_ready = (r_state != TWO);
`else
    // Single slot: room exists if empty or the head leaves this cycle.
    assign id_ready = !w_main_vld || ex_ready;
`endif

    assign ex_valid = w_main_vld;
    assign w_accept = id_valid && id_ready;
    assign w_issue  = w_main_vld && ex_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slot load selection; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_main_d    = w_in_pkt;
`ifdef EX_ISSUE_SKID_EN
        w_skid_ld   = 1'b0;
`endif
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
`ifdef EX_ISSUE_SKID_EN
                if (w_accept && w_issue) begin
                    w_main_ld = 1'b1;
                end else if (w_accept) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_issue) begin
                    w_state_nxt = EMPTY;
                end
`else
                if (w_accept) begin
                    w_main_ld = 1'b1;
                end else if (w_issue) begin
                    w_state_nxt = EMPTY;
                end
`endif
            end
            TWO: begin
`ifdef EX_ISSUE_SKID_EN
                if (w_issue) begin
                    w_main_ld   = 1'b1;
                    w_main_d    = w_skid_q;
                    w_state_nxt = ONE;
                end
`else
                w_state_nxt = EMPTY;
`endif
            end
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_ld   = 1'b0;
`ifdef EX_ISSUE_SKID_EN
            w_skid_ld   = 1'b0;
`endif
        end
    end

    assign w_main_clr = flush || (w_issue && !w_main_ld);

    ex_issue_slot u_main (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_main_clr),
        .i_ld  (w_main_ld),
        .i_d   (w_main_d),
        .o_vld (w_main_vld),
        .o_q   (w_main_q)
    );

`ifdef EX_ISSUE_SKID_EN
    assign w_skid_clr = flush || ((r_state == TWO) && w_issue);

    ex_issue_slot u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_skid_clr),
        .i_ld  (w_skid_ld),
        .i_d   (w_in_pkt),
        .o_vld (w_skid_vld),
        .o_q   (w_skid_q)
    );
`endif

    assign ex_alu_op = w_main_q.alu_op;
    assign ex_src1   = w_main_q.src1;
    assign ex_src2   = w_main_q.src2;
    assign ex_rd     = w_main_q.rd;
    assign ex_rf_we  = w_main_q.rf_we;
    assign ex_pc     = w_main_q.pc;

endmodule
